// File: rtl/ether_rx_ctl_if.sv
// Bundle between the RX control/link supervisor and the SFP MAC receive side.
// The master modport is the controller; the slave modport is the MAC/status side.
interface ether_rx_ctl_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 stat_rx_block_lock;
  logic                 stat_rx_status;
  logic                 stat_rx_local_fault;
  logic [1:0]           stat_rx_bad_fcs;
  logic                 cnt_clear;
  logic                 ctl_rx_enable;
  logic                 ctl_rx_check_preamble;
  logic                 ctl_rx_check_sfd;
  logic                 ctl_rx_delete_fcs;
  logic                 ctl_rx_ignore_fcs;
  logic [14:0]          ctl_rx_max_packet_len;
  logic [7:0]           ctl_rx_min_packet_len;
  logic                 rx_reset_req;
  logic                 tx_send_rfi_req;
  logic                 link_up;
  logic [CNT_WIDTH-1:0] link_down_cnt;
  logic [CNT_WIDTH-1:0] bad_fcs_cnt;

  modport master (
    input  stat_rx_block_lock, stat_rx_status, stat_rx_local_fault, stat_rx_bad_fcs, cnt_clear,
    output ctl_rx_enable, ctl_rx_check_preamble, ctl_rx_check_sfd, ctl_rx_delete_fcs,
           ctl_rx_ignore_fcs, ctl_rx_max_packet_len, ctl_rx_min_packet_len,
           rx_reset_req, tx_send_rfi_req, link_up, link_down_cnt, bad_fcs_cnt
  );

  modport slave (
    output stat_rx_block_lock, stat_rx_status, stat_rx_local_fault, stat_rx_bad_fcs, cnt_clear,
    input  ctl_rx_enable, ctl_rx_check_preamble, ctl_rx_check_sfd, ctl_rx_delete_fcs,
           ctl_rx_ignore_fcs, ctl_rx_max_packet_len, ctl_rx_min_packet_len,
           rx_reset_req, tx_send_rfi_req, link_up, link_down_cnt, bad_fcs_cnt
  );
endinterface

// File: rtl/ether_rx_ctl.sv
// RX control and link supervisor: drives MAC RX configuration, debounces link-up,
// pulses an RX reset on lock timeout, requests RFI while down, keeps status counters.
module ether_rx_ctl #(
  parameter int STABLE_CYCLES    = 1024,
  parameter int LOCK_TIMEOUT     = 1048576,
  parameter int RST_PULSE_CYCLES = 16,
  parameter int CNT_WIDTH        = 16,
  parameter int MAX_PKT_LEN      = 9600,
  parameter int MIN_PKT_LEN      = 64
) (
  input  logic          ctl_clk,
  input  logic          ctl_reset,
  ether_rx_ctl_if.master bus
);
  localparam int T_A  = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int TMAX = (T_A > RST_PULSE_CYCLES) ? T_A : RST_PULSE_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_LOCK, WAIT_STABLE, UP, RESET_RX} state_t;

  state_t               state, next_state;
  logic [TW-1:0]        timer, next_timer;
  logic                 good;
  logic                 enable, reset_req, rfi_req, link_up;
  logic [CNT_WIDTH-1:0] link_down_cnt, bad_fcs_cnt;

  // Moore outputs {enable, reset_req, rfi_req, link_up} for a given state
  function automatic logic [3:0] moore(input state_t s);
    case (s)
      WAIT_LOCK:   moore = 4'b1010;
      WAIT_STABLE: moore = 4'b1010;
      UP:          moore = 4'b1001;
      RESET_RX:    moore = 4'b0110;
      default:     moore = 4'b0000;
    endcase
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, b};
    sat_add = s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  assign good = bus.stat_rx_block_lock & bus.stat_rx_status & ~bus.stat_rx_local_fault;

  always_comb begin
    next_state = state;
    next_timer = timer + 1'b1;
    case (state)
      IDLE: begin
        next_state = WAIT_LOCK;
        next_timer = '0;
      end
      WAIT_LOCK: begin
        if (good) begin
          next_state = WAIT_STABLE;
          next_timer = '0;
        end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
          next_state = RESET_RX;
          next_timer = '0;
        end
      end
      WAIT_STABLE: begin
        if (!good) begin
          next_state = WAIT_LOCK;
          next_timer = '0;
        end else if (timer == TW'(STABLE_CYCLES - 1)) begin
          next_state = UP;
          next_timer = '0;
        end
      end
      UP: begin
        next_timer = '0;
        if (!good) next_state = WAIT_LOCK;
      end
      RESET_RX: begin
        if (timer == TW'(RST_PULSE_CYCLES - 1)) begin
          next_state = WAIT_LOCK;
          next_timer = '0;
        end
      end
      default: begin
        next_state = IDLE;
        next_timer = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they are valid in a state's first cycle
  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset) begin
      state <= IDLE;
      timer <= '0;
      {enable, reset_req, rfi_req, link_up} <= 4'b0000;
    end else begin
      state <= next_state;
      timer <= next_timer;
      {enable, reset_req, rfi_req, link_up} <= moore(next_state);
    end
  end

  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset) begin
      link_down_cnt <= '0;
      bad_fcs_cnt   <= '0;
    end else if (bus.cnt_clear) begin
      link_down_cnt <= '0;
      bad_fcs_cnt   <= '0;
    end else begin
      if (state == UP && !good) link_down_cnt <= sat_add(link_down_cnt, 2'd1);
      if (link_up)              bad_fcs_cnt   <= sat_add(bad_fcs_cnt, bus.stat_rx_bad_fcs);
    end
  end

  assign bus.ctl_rx_enable         = enable;
  assign bus.rx_reset_req          = reset_req;
  assign bus.tx_send_rfi_req       = rfi_req;
  assign bus.link_up               = link_up;
  assign bus.link_down_cnt         = link_down_cnt;
  assign bus.bad_fcs_cnt           = bad_fcs_cnt;
  assign bus.ctl_rx_check_preamble = 1'b1;
  assign bus.ctl_rx_check_sfd      = 1'b1;
  assign bus.ctl_rx_delete_fcs     = 1'b1;
  assign bus.ctl_rx_ignore_fcs     = 1'b0;
  assign bus.ctl_rx_max_packet_len = 15'(MAX_PKT_LEN);
  assign bus.ctl_rx_min_packet_len = 8'(MIN_PKT_LEN);
endmodule

// File: tb/tb_ether_rx_ctl.sv
// Bench for ether_rx_ctl: directed link scenarios with literal expectations, then
// randomized link behaviour checked every cycle against a behavioural model.
module tb_ether_rx_ctl;
  localparam int SC   = 8;
  localparam int LT   = 100;
  localparam int RP   = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic ctl_reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ether_rx_ctl_if #(.CNT_WIDTH(CW)) bus ();

  ether_rx_ctl #(
    .STABLE_CYCLES(SC), .LOCK_TIMEOUT(LT), .RST_PULSE_CYCLES(RP),
    .CNT_WIDTH(CW), .MAX_PKT_LEN(9600), .MIN_PKT_LEN(64)
  ) dut (
    .ctl_clk(clk),
    .ctl_reset(ctl_reset),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase name, cycles spent in phase, two counters
  string mphase = "idle";
  int    mcyc   = 0;
  int    mldc   = 0;
  int    mbfc   = 0;

  always @(posedge clk or posedge ctl_reset) begin
    bit g;
    if (ctl_reset) begin
      mphase = "idle"; mcyc = 0; mldc = 0; mbfc = 0;
    end else begin
      g = bus.stat_rx_block_lock && bus.stat_rx_status && !bus.stat_rx_local_fault;
      if (bus.cnt_clear) begin
        mldc = 0; mbfc = 0;
      end else if (mphase == "up") begin
        if (!g) mldc = (mldc < CMAX) ? mldc + 1 : CMAX;
        mbfc = (mbfc + int'(bus.stat_rx_bad_fcs) > CMAX) ? CMAX : mbfc + int'(bus.stat_rx_bad_fcs);
      end
      if (mphase == "idle") begin
        mphase = "lock"; mcyc = 0;
      end else if (mphase == "lock") begin
        if (g) begin mphase = "stable"; mcyc = 0; end
        else if (mcyc + 1 == LT) begin mphase = "rst"; mcyc = 0; end
        else mcyc++;
      end else if (mphase == "stable") begin
        if (!g) begin mphase = "lock"; mcyc = 0; end
        else if (mcyc + 1 == SC) begin mphase = "up"; mcyc = 0; end
        else mcyc++;
      end else if (mphase == "up") begin
        if (!g) begin mphase = "lock"; mcyc = 0; end
      end else begin
        if (mcyc + 1 == RP) begin mphase = "lock"; mcyc = 0; end
        else mcyc++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("enable",  bus.ctl_rx_enable,   (mphase == "lock" || mphase == "stable" || mphase == "up"));
    chk("rst_req", bus.rx_reset_req,    (mphase == "rst"));
    chk("rfi_req", bus.tx_send_rfi_req, (mphase == "lock" || mphase == "stable" || mphase == "rst"));
    chk("link_up", bus.link_up,         (mphase == "up"));
    chk("ldc",     bus.link_down_cnt,   mldc);
    chk("bfc",     bus.bad_fcs_cnt,     mbfc);
    chk("const_flags", {bus.ctl_rx_check_preamble, bus.ctl_rx_check_sfd,
                        bus.ctl_rx_delete_fcs, bus.ctl_rx_ignore_fcs}, 4'b1110);
    chk("max_len", bus.ctl_rx_max_packet_len, 9600);
    chk("min_len", bus.ctl_rx_min_packet_len, 64);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit lock, input bit st, input bit lf, input logic [1:0] fcs, input bit clr);
    @(negedge clk);
    bus.stat_rx_block_lock  = lock;
    bus.stat_rx_status      = st;
    bus.stat_rx_local_fault = lf;
    bus.stat_rx_bad_fcs     = fcs;
    bus.cnt_clear           = clr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    ctl_reset = 1'b1;
    @(negedge clk);
    ctl_reset = 1'b0;
  endtask

  initial begin
    int exp_bfc [6] = '{3, 6, 9, 12, 15, 15};
    bus.stat_rx_block_lock = 0; bus.stat_rx_status = 0; bus.stat_rx_local_fault = 0;
    bus.stat_rx_bad_fcs = 0; bus.cnt_clear = 0;
    #2;
    chk("rst_link_up", bus.link_up, 0);
    chk("rst_enable", bus.ctl_rx_enable, 0);
    chk("rst_rfi", bus.tx_send_rfi_req, 0);
    chk("rst_const_max", bus.ctl_rx_max_packet_len, 9600);
    repeat (2) @(negedge clk);
    ctl_reset = 1'b0;

    // Lock never arrives: timeout reset pulse, repeating every LT+RP cycles
    step(1);
    chk("t3_enable", bus.ctl_rx_enable, 1);
    chk("t3_rfi", bus.tx_send_rfi_req, 1);
    step(LT);
    chk("t3_rst_on", bus.rx_reset_req, 1);
    chk("t3_enable_off", bus.ctl_rx_enable, 0);
    step(RP - 1);
    chk("t3_rst_last", bus.rx_reset_req, 1);
    step(1);
    chk("t3_rst_off", bus.rx_reset_req, 0);
    chk("t3_enable_back", bus.ctl_rx_enable, 1);
    step(LT - 1);
    chk("t3_still_wait", bus.rx_reset_req, 0);
    step(1);
    chk("t3_rst_again", bus.rx_reset_req, 1);

    // Basic link-up: good from 5 cycles after reset, UP after SC cycles in stable
    do_reset();
    step(5);
    set_in(1, 1, 0, 0, 0);
    step(1);
    chk("t1_stable_link", bus.link_up, 0);
    chk("t1_stable_rfi", bus.tx_send_rfi_req, 1);
    step(SC - 1);
    chk("t1_not_yet", bus.link_up, 0);
    step(1);
    chk("t1_link_up", bus.link_up, 1);
    chk("t1_rfi_off", bus.tx_send_rfi_req, 0);

    // Local fault pulse while up
    set_in(1, 1, 1, 0, 0);
    step(1);
    chk("t4_link_down", bus.link_up, 0);
    chk("t4_rfi", bus.tx_send_rfi_req, 1);
    chk("t4_ldc", bus.link_down_cnt, 1);
    set_in(1, 1, 0, 0, 0);
    step(SC + 1);
    chk("t4_relink", bus.link_up, 1);

    // Status glitch mid-stable restarts the debounce
    set_in(1, 0, 0, 0, 0);
    step(1);
    chk("t2_ldc", bus.link_down_cnt, 2);
    set_in(1, 1, 0, 0, 0);
    step(6);
    set_in(1, 0, 0, 0, 0);
    step(1);
    chk("t2_back_lock", bus.link_up, 0);
    set_in(1, 1, 0, 0, 0);
    step(SC);
    chk("t2_not_yet", bus.link_up, 0);
    step(1);
    chk("t2_link_up", bus.link_up, 1);

    // Bad-FCS accumulation and saturation, clear beats increment
    set_in(1, 1, 0, 0, 1);
    step(1);
    chk("t5_clear", bus.bad_fcs_cnt, 0);
    chk("t5_clear_ldc", bus.link_down_cnt, 0);
    set_in(1, 1, 0, 3, 0);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("t5_bfc", bus.bad_fcs_cnt, exp_bfc[i]);
    end
    set_in(1, 1, 0, 3, 1);
    step(1);
    chk("t5_clear_wins", bus.bad_fcs_cnt, 0);
    set_in(1, 1, 0, 0, 0);

    // Asynchronous reset mid-cycle while up
    @(posedge clk);
    #3 ctl_reset = 1'b1;
    #1;
    chk("t6_link_up", bus.link_up, 0);
    chk("t6_enable", bus.ctl_rx_enable, 0);
    chk("t6_rfi", bus.tx_send_rfi_req, 0);
    chk("t6_rst_req", bus.rx_reset_req, 0);
    @(negedge clk);
    ctl_reset = 1'b0;
    step(2);
    chk("t6_stable", bus.link_up, 0);
    step(SC - 1);
    chk("t6_not_yet", bus.link_up, 0);
    step(1);
    chk("t6_relink", bus.link_up, 1);

    // Randomized regimes: mostly good, dead link, noisy inputs
    for (int seg = 0; seg < 40; seg++) begin
      int r;
      int len;
      r   = $urandom_range(0, 2);
      len = $urandom_range(20, 150);
      if ($urandom_range(0, 9) == 0) do_reset();
      for (int c = 0; c < len; c++) begin
        bit lk, st, lf;
        case (r)
          0: begin
            lk = 1; st = 1; lf = 0;
            if ($urandom_range(0, 39) == 0) begin
              case ($urandom_range(0, 2))
                0: lk = 0;
                1: st = 0;
                default: lf = 1;
              endcase
            end
          end
          1: begin lk = ($urandom_range(0, 9) == 0); st = 0; lf = 1; end
          default: begin lk = $urandom_range(0, 1); st = $urandom_range(0, 1); lf = $urandom_range(0, 1); end
        endcase
        set_in(lk, st, lf, 2'($urandom_range(0, 3)), ($urandom_range(0, 63) == 0));
      end
    end
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
